frame_tx_sequencer: RTL and testbench

//  Serialises the 11-bit switch frame (idle mark, start, 7 data, parity, stop) onto one line.

---
 rtl/frame_tx_sequencer.sv | 103 ++++++++++
 tb/tb_frame_tx_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_tx_sequencer.sv
// rtl/frame_tx_sequencer.sv - serialises a latched parallel frame onto a single TX line, LSB first
module frame_tx_sequencer #(
  parameter int BAUD_DIV   = 5208,
  parameter int FRAME_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  logic [CW-1:0]         baud_cnt, baud_cnt_n;
  logic                  start_d;
  logic                  start_edge;
  logic                  txd_n, busy_n, done_n;

  // start_d resets high so a button held through reset is not seen as a fresh press
  assign start_edge = start & ~start_d;

  // State, datapath and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '1;
      bit_idx  <= '0;
      baud_cnt <= '0;
      start_d  <= 1'b1;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      baud_cnt <= baud_cnt_n;
      start_d  <= start;
      txd      <= txd_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state logic; txd/busy/done are computed one cycle ahead so the pins come straight from flops
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    baud_cnt_n = baud_cnt;
    txd_n      = 1'b1;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          shreg_n    = frame;
          bit_idx_n  = '0;
          baud_cnt_n = '0;
          state_n    = SEND;
          txd_n      = frame[0];
          busy_n     = 1'b1;
        end
      end
      SEND: begin
        busy_n = 1'b1;
        txd_n  = shreg[0];
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b1, shreg[FRAME_BITS-1:1]};
          txd_n      = shreg[1];
          if (bit_idx == IDX_LAST) begin
            // Final bit period over: line back to mark, busy drops with the done pulse
            state_n = IDLE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_tx_sequencer.sv
// tb/tb_frame_tx_sequencer.sv - randomized self-checking bench for frame_tx_sequencer
module tb_frame_tx_sequencer;

  localparam int BAUD = 4;
  localparam int FB   = 11;
  localparam int NB   = FB * BAUD;

  logic          clk;
  logic          rst;
  logic          start;
  logic [FB-1:0] frame;
  logic          txd, busy, done;

  int tests  = 0;
  int failed = 0;

  frame_tx_sequencer #(.BAUD_DIV(BAUD), .FRAME_BITS(FB)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .frame(frame),
    .txd  (txd),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a window of NB cycles after the accepting edge,
  // bit k of the latched frame occupies cycles k*BAUD .. k*BAUD+BAUD-1 of that window
  logic          m_busy  = 1'b0;
  logic          m_done  = 1'b0;
  logic          m_prev  = 1'b1;
  int            m_j     = 0;
  logic [FB-1:0] m_frame = '1;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_prev = 1'b1;
      m_j    = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_j++;
        if (m_j == NB) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (start && !m_prev) begin
        m_busy  = 1'b1;
        m_j     = 0;
        m_frame = frame;
      end
      m_prev = start;
    end
  end

  function automatic logic [2:0] exp_out();
    logic t;
    t = m_busy ? m_frame[m_j / BAUD] : 1'b1;
    return {t, m_busy, m_done};
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    frame = FB'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c > 0) begin
        tests++;
        if ({txd, busy, done} !== 3'b100) begin
          failed++;
          $display("FAIL reset_hold c=%0d got=%b exp=100", c, {txd, busy, done});
        end
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== 3'b100) begin
        failed++;
        $display("FAIL reset_held_start c=%0d got=%b exp=100", c, {txd, busy, done});
      end
    end
  endtask

  task automatic test_basic();
    int            bcnt, dcnt;
    logic [FB-1:0] got;
    bcnt  = 0;
    dcnt  = 0;
    got   = '0;
    frame = 11'b110_1010_1011;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL basic_cycle c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (busy) begin
        if (bcnt < NB && bcnt % BAUD == 1) got[bcnt / BAUD] = txd;
        bcnt++;
      end
      if (done) dcnt++;
    end
    tests++;
    if (got !== 11'b110_1010_1011) begin
      failed++;
      $display("FAIL basic_bits got=%b exp=%b", got, 11'b110_1010_1011);
    end
    tests++;
    if (bcnt != NB) begin
      failed++;
      $display("FAIL basic_busy_len got=%0d exp=%0d", bcnt, NB);
    end
    tests++;
    if (dcnt != 1) begin
      failed++;
      $display("FAIL basic_done_count got=%0d exp=1", dcnt);
    end
    start = 1'b0;
  endtask

  task automatic test_ignore_start();
    int bcnt, dcnt;
    bcnt  = 0;
    dcnt  = 0;
    frame = FB'($urandom);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL ignore_cycle c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (busy) bcnt++;
      if (done) dcnt++;
      if (c == 10) start = 1'b0;
      if (c == 11) start = 1'b1;
    end
    tests++;
    if (bcnt != NB || dcnt != 1) begin
      failed++;
      $display("FAIL ignore_counts busy=%0d done=%0d exp busy=%0d done=1", bcnt, dcnt, NB);
    end
    start = 1'b0;
  endtask

  task automatic test_frame_change();
    int            bcnt;
    logic [FB-1:0] f, got;
    bcnt  = 0;
    got   = '0;
    f     = FB'($urandom);
    frame = f;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL change_cycle c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (busy) begin
        if (bcnt < NB && bcnt % BAUD == 1) got[bcnt / BAUD] = txd;
        bcnt++;
      end
      if (c == 5) frame = ~f;
    end
    tests++;
    if (got !== f) begin
      failed++;
      $display("FAIL change_bits got=%b exp=%b", got, f);
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [FB-1:0] f2;
    int            dcnt;
    bit            seen;
    dcnt  = 0;
    seen  = 1'b0;
    f2    = FB'($urandom);
    frame = FB'($urandom);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL b2b_first c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (c == 2) start = 1'b0;
      if (m_done) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      failed++;
      $display("FAIL b2b_timeout got=no_done exp=done_within_60");
    end
    start = 1'b1;
    frame = f2;
    @(negedge clk);
    tests++;
    if ({txd, busy, done} !== {f2[0], 1'b1, 1'b0}) begin
      failed++;
      $display("FAIL b2b_restart got=%b exp=%b", {txd, busy, done}, {f2[0], 1'b1, 1'b0});
    end
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL b2b_second c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (done) dcnt++;
    end
    tests++;
    if (dcnt != 1) begin
      failed++;
      $display("FAIL b2b_done_count got=%0d exp=1", dcnt);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dcnt;
    dcnt  = 0;
    frame = FB'($urandom);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL rstmid_pre c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({txd, busy, done} !== 3'b100) begin
      failed++;
      $display("FAIL rstmid_abort got=%b exp=100", {txd, busy, done});
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== 3'b100) begin
        failed++;
        $display("FAIL rstmid_idle c=%0d got=%b exp=100", c, {txd, busy, done});
      end
    end
    frame = FB'($urandom);
    start = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if ({txd, busy, done} !== exp_out()) begin
        failed++;
        $display("FAIL rstmid_resend c=%0d got=%b exp=%b", c, {txd, busy, done}, exp_out());
      end
      if (done) dcnt++;
    end
    tests++;
    if (dcnt != 1) begin
      failed++;
      $display("FAIL rstmid_done_count got=%0d exp=1", dcnt);
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int gap, run;
      gap   = $urandom_range(1, 5);
      run   = $urandom_range(30, 56);
      start = 1'b0;
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        tests++;
        if ({txd, busy, done} !== exp_out()) begin
          failed++;
          $display("FAIL random_gap it=%0d c=%0d got=%b exp=%b", it, c, {txd, busy, done}, exp_out());
        end
      end
      frame = FB'($urandom);
      start = 1'b1;
      for (int c = 0; c < run; c++) begin
        @(negedge clk);
        tests++;
        if ({txd, busy, done} !== exp_out()) begin
          failed++;
          $display("FAIL random_run it=%0d c=%0d got=%b exp=%b", it, c, {txd, busy, done}, exp_out());
        end
        if ($urandom_range(0, 7) == 0) frame = FB'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    frame = '0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_frame_change();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
